cdc_codec_param: RTL and testbench

CDC_CODEC_PARAM -- requirements
Module: cdc_codec_param

---
 rtl/cdc_codec_pkg.sv | 17 +
 rtl/toggle_sync.sv | 30 +++
 rtl/cdc_codec_param.sv | 200 ++++++++++++++++++++
 tb/tb_cdc_codec_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_codec_pkg.sv
// Shared encodings for the CRC / Hamming codec whose result crosses from clk_1 to clk_3.
package cdc_codec_pkg;
  localparam logic [1:0] MODE_CRC_GEN = 2'd0;
  localparam logic [1:0] MODE_CRC_CHK = 2'd1;
  localparam logic [1:0] MODE_HAM_COR = 2'd2;
  localparam logic [1:0] MODE_HAM_ENC = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [8:0] DEFAULT_CRC_POLY = 9'h18D;

  function automatic logic is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction
endpackage

// File: rtl/toggle_sync.sv
// Carries a toggle flag into another clock domain and emits a one-cycle pulse per toggle.
module toggle_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_in,
  output logic pulse
);
  logic meta_q, sync_q, last_q;
  logic meta_d, sync_d, last_d;

  always_comb begin
    meta_d = tog_in;
    sync_d = meta_q;
    last_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign pulse = sync_q ^ last_q;
endmodule

// File: rtl/cdc_codec_param.sv
// CRC generate/check and Hamming correct/encode computed in clk_1; each result is
// handed to clk_3 with a req/ack toggle handshake and shown there as a one-cycle pulse.
module cdc_codec_param
  import cdc_codec_pkg::*;
#(
  parameter int               MSG_W    = 64,
  parameter int               CRC_W    = 8,
  parameter logic [CRC_W:0]   CRC_POLY = (CRC_W + 1)'(DEFAULT_CRC_POLY),
  parameter int               BPC      = 8,
  parameter int               HAM_R    = 3
) (
  input  logic                     clk_1,
  input  logic                     clk_3,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [MSG_W-1:0]         message,
  input  logic [MSG_W+CRC_W-1:0]   recv_data,
  input  logic [2**HAM_R-2:0]      ham_data,
  output logic                     out_valid,
  output logic [MSG_W+CRC_W-1:0]   out,
  output logic                     err_flag,
  output logic [1:0]               dbg_state
);
  localparam int TOT_W = MSG_W + CRC_W;
  localparam int N     = 2**HAM_R - 1;
  localparam int K     = N - HAM_R;
  localparam int CYC   = TOT_W / BPC;
  localparam int CNT_W = $clog2(CYC + 1);

  // Request path: in_valid is taken only when in_ready (state IDLE) is high.
  // The result register is frozen from CALC exit until the ack returns, so clk_3 may sample it freely.

  logic [1:0]       state_q, state_d, mode_q, mode_d;
  logic [TOT_W-1:0] data_q, data_d, shift_q, shift_d, res_q, res_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_err_q, res_err_d, req_tog_q, req_tog_d;
  logic [N-1:0]     ham_in, ham_fix;
  logic [HAM_R-1:0] syn;
  logic             req_pulse, ack_pulse;
  logic             ov_q, ov_d, err3_q, err3_d, ack_tog_q, ack_tog_d;
  logic [TOT_W-1:0] out_q, out_d;

  // Augmented long division: the bit shifted out of the top decides the subtract.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                input logic [BPC-1:0] bits);
    logic [CRC_W-1:0] c;
    logic             top;
    c = r;
    for (int i = BPC - 1; i >= 0; i--) begin
      top = c[CRC_W-1];
      c   = (c << 1) | CRC_W'(bits[i]);
      if (top) c = c ^ CRC_POLY[CRC_W-1:0];
    end
    return c;
  endfunction

  function automatic logic [HAM_R-1:0] ham_syn(input logic [N-1:0] cw);
    logic [HAM_R-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) if (cw[i]) s = s ^ HAM_R'(i + 1);
    return s;
  endfunction

  // With parity slots zero, the syndrome bit k is exactly the parity needed at 2^k.
  function automatic logic [N-1:0] ham_enc(input logic [K-1:0] d);
    logic [N-1:0]     cw;
    logic [HAM_R-1:0] s;
    int               j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= N; p++) begin
      if (!is_pow2(p)) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    s = ham_syn(cw);
    for (int k = 0; k < HAM_R; k++) cw[(1 << k) - 1] = s[k];
    return cw;
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    data_d    = data_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    req_tog_d = req_tog_q;
    crc_nxt   = crc_step(crc_q, shift_q[TOT_W-1 -: BPC]);
    ham_in    = data_q[N-1:0];
    syn       = ham_syn(ham_in);
    ham_fix   = ham_in;
    if (syn != '0) ham_fix[syn - 1'b1] = ~ham_in[syn - 1'b1];
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d = mode;
          if (mode == MODE_CRC_GEN)      data_d = {message, CRC_W'(0)};
          else if (mode == MODE_CRC_CHK) data_d = recv_data;
          else                           data_d = TOT_W'(ham_data);
          shift_d = data_d;
          crc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mode_q == MODE_CRC_GEN || mode_q == MODE_CRC_CHK) begin
          crc_d   = crc_nxt;
          shift_d = shift_q << BPC;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CYC - 1)) begin
            state_d   = ST_SEND;
            req_tog_d = ~req_tog_q;
            if (mode_q == MODE_CRC_GEN) begin
              res_d     = {data_q[TOT_W-1:CRC_W], crc_nxt};
              res_err_d = 1'b0;
            end else begin
              res_d     = {TOT_W{crc_nxt != '0}};
              res_err_d = crc_nxt != '0;
            end
          end
        end else begin
          state_d   = ST_SEND;
          req_tog_d = ~req_tog_q;
          if (mode_q == MODE_HAM_COR) begin
            res_d     = TOT_W'(ham_fix);
            res_err_d = syn != '0;
          end else begin
            res_d     = TOT_W'(ham_enc(data_q[K-1:0]));
            res_err_d = 1'b0;
          end
        end
      end
      ST_SEND: if (ack_pulse) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      data_q    <= '0;
      shift_q   <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_err_q <= 1'b0;
      req_tog_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      data_q    <= data_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      req_tog_q <= req_tog_d;
    end
  end

  assign in_ready  = state_q == ST_IDLE;
  assign dbg_state = state_q;

  toggle_sync u_req_sync (.clk(clk_3), .rst_n(rst_n), .tog_in(req_tog_q), .pulse(req_pulse));
  toggle_sync u_ack_sync (.clk(clk_1), .rst_n(rst_n), .tog_in(ack_tog_q), .pulse(ack_pulse));

  always_comb begin
    ov_d      = req_pulse;
    out_d     = req_pulse ? res_q : '0;
    err3_d    = req_pulse & res_err_q;
    ack_tog_d = ack_tog_q ^ req_pulse;
  end

  always_ff @(posedge clk_3 or negedge rst_n) begin
    if (!rst_n) begin
      ov_q      <= 1'b0;
      out_q     <= '0;
      err3_q    <= 1'b0;
      ack_tog_q <= 1'b0;
    end else begin
      ov_q      <= ov_d;
      out_q     <= out_d;
      err3_q    <= err3_d;
      ack_tog_q <= ack_tog_d;
    end
  end

  assign out_valid = ov_q;
  assign out       = out_q;
  assign err_flag  = err3_q;
endmodule

// File: tb/tb_cdc_codec_param.sv
// Directed and random requests against a division / position-based reference model;
// results are matched in order at clk_3 through an expected queue.
module tb_cdc_codec_param;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int MSG_W = 64;
  localparam int CRC_W = 8;
  localparam int BPC   = 8;
  localparam int HAM_R = 3;
  localparam int TOT_W = MSG_W + CRC_W;
  localparam int N     = 7;
  localparam int K     = 4;
  localparam int W     = TOT_W + 1;
  localparam logic [CRC_W:0] POLY = 9'h18D;

  // clock / reset
  logic clk_1 = 1'b0;
  logic clk_3 = 1'b0;
  logic rst_n = 1'b0;
  real  half1 = 2.5;
  real  half3 = 3.5;
  always #(half1) clk_1 = ~clk_1;
  always #(half3) clk_3 = ~clk_3;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       mode = '0;
  logic [MSG_W-1:0] message = '0;
  logic [TOT_W-1:0] recv_data = '0;
  logic [N-1:0]     ham_data = '0;
  logic             out_valid;
  logic [TOT_W-1:0] out;
  logic             err_flag;
  logic [1:0]       dbg_state;

  cdc_codec_param dut (
    .clk_1(clk_1), .clk_3(clk_3), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .message(message), .recv_data(recv_data), .ham_data(ham_data),
    .out_valid(out_valid), .out(out), .err_flag(err_flag), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic prev_v = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // reference model
  function automatic logic [CRC_W-1:0] crc_rem(input logic [TOT_W-1:0] v);
    logic [TOT_W-1:0] t;
    t = v;
    for (int i = TOT_W - 1; i >= CRC_W; i--)
      if (t[i]) t = t ^ (TOT_W'(POLY) << (i - CRC_W));
    return t[CRC_W-1:0];
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] m, input logic [MSG_W-1:0] msg,
                                         input logic [TOT_W-1:0] rd, input logic [N-1:0] hd);
    logic [W-1:0] r;
    logic [N-1:0] cw;
    int s, j;
    logic par;
    r = '0;
    case (m)
      2'd0: r = {1'b0, msg, crc_rem({msg, 8'h00})};
      2'd1: if (crc_rem(rd) != 0) r = '1;
      2'd2: begin
        s = 0;
        for (int p = 1; p <= N; p++) if (hd[p-1]) s = s ^ p;
        cw = hd;
        if (s != 0) cw[s-1] = ~cw[s-1];
        r[N-1:0] = cw;
        r[W-1]   = s != 0;
      end
      default: begin
        cw = '0;
        j  = 0;
        for (int p = 1; p <= N; p++) begin
          if ((p & (p - 1)) != 0) begin
            cw[p-1] = hd[j];
            j++;
          end
        end
        for (int k = 0; k < HAM_R; k++) begin
          par = 1'b0;
          for (int p = 1; p <= N; p++)
            if (((p >> k) & 1) == 1 && p != (1 << k)) par = par ^ cw[p-1];
          cw[(1 << k) - 1] = par;
        end
        r[N-1:0] = cw;
      end
    endcase
    return r;
  endfunction

  task automatic gen_rand(output logic [1:0] m, output logic [MSG_W-1:0] msg,
                          output logic [TOT_W-1:0] rd, output logic [N-1:0] hd);
    logic [MSG_W-1:0] cm;
    m   = 2'($urandom_range(0, 3));
    msg = {$urandom, $urandom};
    cm  = {$urandom, $urandom};
    rd  = {cm, crc_rem({cm, 8'h00})};
    if ($urandom_range(0, 1) == 1) rd = rd ^ (TOT_W'(1) << $urandom_range(0, TOT_W - 1));
    hd  = N'($urandom);
  endtask

  // scoreboard
  always @(negedge clk_3) begin
    if (out_valid) begin
      check("pulse_width", W'(prev_v), '0);
      check("expected_pending", W'(exp_q.size() == 0), '0);
      if (exp_q.size() != 0) check("result", {err_flag, out}, exp_q.pop_front());
    end else begin
      check("idle_out_zero", W'(out), '0);
    end
    prev_v = out_valid;
  end

  // drivers
  task automatic drive_req(input logic [1:0] m, input logic [MSG_W-1:0] msg,
                           input logic [TOT_W-1:0] rd, input logic [N-1:0] hd,
                           input logic [W-1:0] exp_v);
    int t;
    t = 0;
    @(negedge clk_1);
    while (!in_ready && t < 300) begin
      @(negedge clk_1);
      t++;
    end
    check("ready_before_req", W'(in_ready), W'(1));
    mode = m; message = msg; recv_data = rd; ham_data = hd; in_valid = 1'b1;
    exp_q.push_back(exp_v);
    @(negedge clk_1);
    in_valid = 1'b0;
    check("busy_after_accept", W'(in_ready), '0);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < budget) begin
      @(negedge clk_1);
      t++;
    end
    check("drain", W'(exp_q.size()), '0);
    check("ready_after_drain", W'(in_ready), W'(1));
  endtask

  task automatic back_to_back();
    logic [1:0]       m;
    logic [MSG_W-1:0] msg;
    logic [TOT_W-1:0] rd;
    logic [N-1:0]     hd;
    logic             just_acc;
    just_acc = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_1);
      if (just_acc) check("ready_low_while_busy", W'(in_ready), '0);
      gen_rand(m, msg, rd, hd);
      mode = m; message = msg; recv_data = rd; ham_data = hd; in_valid = 1'b1;
      just_acc = in_ready;
      if (in_ready) exp_q.push_back(model(m, msg, rd, hd));
    end
    @(negedge clk_1);
    in_valid = 1'b0;
    if (just_acc) check("ready_low_while_busy", W'(in_ready), '0);
    wait_drain(600);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected results outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]       m;
    logic [MSG_W-1:0] msg;
    logic [TOT_W-1:0] rd;
    logic [N-1:0]     hd;

    repeat (3) @(negedge clk_1);
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_out_err", {err_flag, out}, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_1);

    drive_req(2'd0, 64'h1, '0, '0, {1'b0, 64'h1, 8'h8D});
    wait_drain(300);
    drive_req(2'd1, '0, {64'h1, 8'h8D}, '0, '0);
    drive_req(2'd1, '0, {64'h1, 8'h8D} ^ (TOT_W'(1) << 40), '0, '1);
    drive_req(2'd2, '0, '0, 7'b0010000, {1'b1, 72'h0});
    drive_req(2'd2, '0, '0, 7'b0000111, {1'b0, 72'h7});
    drive_req(2'd3, '0, '0, 7'b0000001, {1'b0, 72'h7});
    wait_drain(300);

    for (int i = 0; i < 16; i++) begin
      gen_rand(m, msg, rd, hd);
      drive_req(m, msg, rd, hd, model(m, msg, rd, hd));
    end
    wait_drain(300);

    half1 = 2.0; half3 = 3.5;
    repeat (4) @(negedge clk_1);
    back_to_back();
    half1 = 3.5; half3 = 1.5;
    repeat (4) @(negedge clk_1);
    back_to_back();

    // abort a mode-0 job while it is still computing
    @(negedge clk_1);
    mode = 2'd0; message = {$urandom, $urandom}; in_valid = 1'b1;
    @(negedge clk_1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk_1);
    rst_n = 1'b0;
    #1;
    check("abort_reset_in_ready", W'(in_ready), W'(1));
    check("abort_reset_out_valid", W'(out_valid), '0);
    repeat (2) @(negedge clk_1);
    rst_n = 1'b1;
    check("abort_release_in_ready", W'(in_ready), W'(1));
    repeat (60) @(negedge clk_1);
    msg = {$urandom, $urandom};
    drive_req(2'd0, msg, '0, '0, model(2'd0, msg, '0, '0));
    wait_drain(300);

    repeat (50) @(negedge clk_1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
